// File: rtl/uart_tx_if.sv
// Byte stream into the UART transmitter: a parallel byte qualified by valid,
// accepted on any rising edge where ready is also high.
interface uart_tx_if #(
    parameter int WIDTH_DATA = 8
);
    logic [WIDTH_DATA-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: shifts one accepted byte out as start bit, data LSB first,
// optional even parity, then one or two stop bits. The frame format is
// captured together with the byte, so reconfiguring mid-frame only affects
// the following frame.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int WIDTH_DATA   = 8,
    parameter int WIDTH_CNT    = 16
) (
    input  logic       clk,
    input  logic       rst,
    uart_tx_if.slave   stream,
    input  logic       parity_bit_config,
    input  logic       stop_bit_config,
    output logic       tx,
    output logic       tx_busy
);

    localparam int IDX_W = (WIDTH_DATA > 1) ? $clog2(WIDTH_DATA) : 1;

    localparam logic [WIDTH_CNT-1:0] CNT_LAST = WIDTH_CNT'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(WIDTH_DATA - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP1  = 3'd4;
    localparam logic [2:0] STOP2  = 3'd5;

    logic [2:0]            state;
    logic [WIDTH_CNT-1:0]  baud_cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [WIDTH_DATA-1:0] shift_reg;
    logic [WIDTH_DATA-1:0] shift_next;
    logic                  frame_parity_en;
    logic                  frame_two_stop;
    logic                  frame_parity_bit;
    logic                  tx_reg;
    logic                  bit_end;

    assign bit_end    = (baud_cnt == CNT_LAST);
    assign shift_next = shift_reg >> 1;

    assign stream.tx_ready = (state == IDLE);
    assign tx_busy         = (state != IDLE);
    assign tx              = tx_reg;

    // Baud counter: parked at 0 while idle, wraps to 0 at the end of each bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= '0;
        end else if (state == IDLE || bit_end) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + WIDTH_CNT'(1);
        end
    end

    // Frame sequencer; tx is registered with the level of the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            bit_idx          <= '0;
            shift_reg        <= '0;
            frame_parity_en  <= 1'b0;
            frame_two_stop   <= 1'b0;
            frame_parity_bit <= 1'b0;
            tx_reg           <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (stream.tx_valid) begin
                        state            <= START;
                        bit_idx          <= '0;
                        shift_reg        <= stream.tx_data;
                        frame_parity_en  <= parity_bit_config;
                        frame_two_stop   <= stop_bit_config;
                        frame_parity_bit <= ^stream.tx_data;
                        tx_reg           <= 1'b0;
                    end
                end

                START: begin
                    if (bit_end) begin
                        state  <= DATA;
                        tx_reg <= shift_reg[0];
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == IDX_LAST) begin
                            bit_idx <= '0;
                            if (frame_parity_en) begin
                                state  <= PARITY;
                                tx_reg <= frame_parity_bit;
                            end else begin
                                state  <= STOP1;
                                tx_reg <= 1'b1;
                            end
                        end else begin
                            bit_idx   <= bit_idx + IDX_W'(1);
                            shift_reg <= shift_next;
                            tx_reg    <= shift_next[0];
                        end
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        state  <= STOP1;
                        tx_reg <= 1'b1;
                    end
                end

                STOP1: begin
                    if (bit_end) begin
                        state  <= frame_two_stop ? STOP2 : IDLE;
                        tx_reg <= 1'b1;
                    end
                end

                STOP2: begin
                    if (bit_end) begin
                        state  <= IDLE;
                        tx_reg <= 1'b1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    tx_reg <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx with a 4-clock bit period.
module tb_uart_tx;

    localparam int CPB = 4;

    logic clk;
    logic rst;
    logic parity_bit_config;
    logic stop_bit_config;
    logic tx;
    logic tx_busy;

    int checks;
    int errors;

    uart_tx_if #(.WIDTH_DATA(8)) bus_if ();

    uart_tx #(
        .CLKS_PER_BIT(CPB),
        .WIDTH_DATA(8),
        .WIDTH_CNT(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stream(bus_if),
        .parity_bit_config(parity_bit_config),
        .stop_bit_config(stop_bit_config),
        .tx(tx),
        .tx_busy(tx_busy)
    );

    // 10 time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Waits (bounded) at negedges for ready, presents a byte and lets it be taken
    // on the next rising edge; valid stays high afterwards when hold is set.
    task automatic send_byte(input logic [7:0] d, input logic hold);
        int n;
        n = 0;
        while (bus_if.tx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout: tx_ready=%b after %0d cycles, required 1", bus_if.tx_ready, n);
        end
        bus_if.tx_data  = d;
        bus_if.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus_if.tx_valid = 1'b0;
    endtask

    // Samples nbits bit periods starting on the cycle after acceptance; records
    // the first level of each bit, whether it held for all CPB cycles, and
    // whether tx_ready was ever seen high inside the frame.
    task automatic capture_frame(input int nbits, output logic [15:0] bits,
                                 output logic [15:0] stable, output logic ready_seen);
        logic first;
        logic same;
        bits       = '0;
        stable     = '0;
        ready_seen = 1'b0;
        for (int k = 0; k < nbits; k++) begin
            first = 1'b0;
            same  = 1'b1;
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (c == 0) first = tx;
                else if (tx !== first) same = 1'b0;
                if (bus_if.tx_ready === 1'b1) ready_seen = 1'b1;
            end
            bits[k]   = first;
            stable[k] = same;
        end
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        bus_if.tx_valid = 1'b1;
        bus_if.tx_data  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({tx, bus_if.tx_ready, tx_busy} !== 3'b110) begin
                errors++;
                $display("[TB] FAIL reset_outputs cycle %0d: tx/ready/busy=%b required 110",
                         i, {tx, bus_if.tx_ready, tx_busy});
            end
        end
        bus_if.tx_valid = 1'b0;
        rst             = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx, bus_if.tx_ready, tx_busy} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL reset_release: tx/ready/busy=%b required 110",
                     {tx, bus_if.tx_ready, tx_busy});
        end
    endtask

    task automatic test_8n1();
        logic [15:0] bits;
        logic [15:0] stable;
        logic        rdy;
        parity_bit_config = 1'b0;
        stop_bit_config   = 1'b0;
        send_byte(8'hA5, 1'b0);
        capture_frame(10, bits, stable, rdy);
        checks++;
        // stop, A5 LSB first, start
        if (bits[9:0] !== 10'b1_10100101_0) begin
            errors++;
            $display("[TB] FAIL 8n1_bits: got %b required %b", bits[9:0], 10'b1_10100101_0);
        end
        checks++;
        if (stable[9:0] !== 10'h3FF || rdy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL 8n1_timing: stable=%b ready_seen=%b required 1111111111/0", stable[9:0], rdy);
        end
        @(negedge clk);
        checks++;
        if ({tx, bus_if.tx_ready, tx_busy} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL 8n1_ready_after_40: tx/ready/busy=%b required 110",
                     {tx, bus_if.tx_ready, tx_busy});
        end
    endtask

    task automatic test_8e2();
        logic [15:0] bits;
        logic [15:0] stable;
        logic        rdy;
        parity_bit_config = 1'b1;
        stop_bit_config   = 1'b1;
        send_byte(8'h07, 1'b0);
        capture_frame(12, bits, stable, rdy);
        checks++;
        // stop, stop, parity 1 (three ones), 07 LSB first, start
        if (bits[11:0] !== 12'b1_1_1_00000111_0) begin
            errors++;
            $display("[TB] FAIL 8e2_bits: got %b required %b", bits[11:0], 12'b1_1_1_00000111_0);
        end
        checks++;
        if (stable[11:0] !== 12'hFFF || rdy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL 8e2_timing: stable=%b ready_seen=%b required all ones/0", stable[11:0], rdy);
        end
        @(negedge clk);
        checks++;
        if (bus_if.tx_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL 8e2_ready_after_48: tx_ready=%b required 1", bus_if.tx_ready);
        end
    endtask

    task automatic test_config_change();
        logic [15:0] bits;
        logic [15:0] stable;
        logic        rdy;
        parity_bit_config = 1'b0;
        stop_bit_config   = 1'b0;
        send_byte(8'h00, 1'b0);
        fork
            capture_frame(10, bits, stable, rdy);
            begin
                repeat (10) @(negedge clk);
                parity_bit_config = 1'b1;
            end
        join
        checks++;
        if (bits[9:0] !== 10'b1_00000000_0 || stable[9:0] !== 10'h3FF) begin
            errors++;
            $display("[TB] FAIL cfg_frame_no_parity: got %b stable %b required %b",
                     bits[9:0], stable[9:0], 10'b1_00000000_0);
        end
        @(negedge clk);
        checks++;
        if ({tx, bus_if.tx_ready} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL cfg_ended_after_stop1: tx/ready=%b required 11", {tx, bus_if.tx_ready});
        end
        send_byte(8'h01, 1'b0);
        capture_frame(11, bits, stable, rdy);
        checks++;
        // stop, parity 1, 01 LSB first, start
        if (bits[10:0] !== 11'b1_1_00000001_0 || stable[10:0] !== 11'h7FF) begin
            errors++;
            $display("[TB] FAIL cfg_next_frame_parity: got %b stable %b required %b",
                     bits[10:0], stable[10:0], 11'b1_1_00000001_0);
        end
        @(negedge clk);
        parity_bit_config = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits;
        logic [15:0] stable;
        logic        rdy;
        parity_bit_config = 1'b0;
        stop_bit_config   = 1'b0;
        send_byte(8'h55, 1'b1);
        bus_if.tx_data = 8'hAA;
        capture_frame(10, bits, stable, rdy);
        checks++;
        if (bits[9:0] !== 10'b1_01010101_0 || stable[9:0] !== 10'h3FF) begin
            errors++;
            $display("[TB] FAIL b2b_first_frame: got %b stable %b required %b",
                     bits[9:0], stable[9:0], 10'b1_01010101_0);
        end
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_not_ready_while_busy: ready_seen=%b required 0", rdy);
        end
        @(negedge clk);
        checks++;
        if ({tx, bus_if.tx_ready} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL b2b_gap_cycle: tx/ready=%b required 11", {tx, bus_if.tx_ready});
        end
        @(posedge clk);
        #1;
        bus_if.tx_valid = 1'b0;
        capture_frame(10, bits, stable, rdy);
        checks++;
        if (bits[9:0] !== 10'b1_10101010_0 || stable[9:0] !== 10'h3FF) begin
            errors++;
            $display("[TB] FAIL b2b_second_frame: got %b stable %b required %b",
                     bits[9:0], stable[9:0], 10'b1_10101010_0);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_frame_reset();
        logic [15:0] bits;
        logic [15:0] stable;
        logic        rdy;
        parity_bit_config = 1'b0;
        stop_bit_config   = 1'b0;
        send_byte(8'h00, 1'b0);
        // start (4) + data bits 0..2 (12) cycles, then first cycle of bit 3
        repeat (17) @(negedge clk);
        checks++;
        if ({tx, tx_busy} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL rst_mid_precondition: tx/busy=%b required 01", {tx, tx_busy});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx, bus_if.tx_ready, tx_busy} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL rst_mid_abort: tx/ready/busy=%b required 110",
                     {tx, bus_if.tx_ready, tx_busy});
        end
        rst = 1'b0;
        @(negedge clk);
        send_byte(8'h3C, 1'b0);
        capture_frame(10, bits, stable, rdy);
        checks++;
        if (bits[9:0] !== 10'b1_00111100_0 || stable[9:0] !== 10'h3FF) begin
            errors++;
            $display("[TB] FAIL rst_mid_next_frame: got %b stable %b required %b",
                     bits[9:0], stable[9:0], 10'b1_00111100_0);
        end
        @(negedge clk);
        checks++;
        if (bus_if.tx_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_mid_ready_after: tx_ready=%b required 1", bus_if.tx_ready);
        end
    endtask

    // Runs every scenario in order and prints the summary.
    initial begin
        checks            = 0;
        errors            = 0;
        rst               = 1'b1;
        parity_bit_config = 1'b0;
        stop_bit_config   = 1'b0;
        bus_if.tx_valid   = 1'b0;
        bus_if.tx_data    = 8'h00;

        $display("[TB] reset");
        test_reset();
        $display("[TB] 8N1 frame");
        test_8n1();
        $display("[TB] 8E2 frame");
        test_8e2();
        $display("[TB] config change mid-frame");
        test_config_change();
        $display("[TB] back-to-back");
        test_back_to_back();
        $display("[TB] mid-frame reset");
        test_mid_frame_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
